rx_engine: RTL and testbench

UART receive engine: the receive-side counterpart of the TX engine on the TramelBlaze I/O bus. It recovers asynchronous serial frames from the `rx` pin using the same baud, word-length and parity controls as the TX engine. It presents received data and status to the processor through the `port_id`/`read_strobe`/`in_port` read path, and raises `rx_rdy` for the top-level interrupt pulse maker.

---
 rtl/uart_pkg.sv | 61 ++++++
 rtl/rx_engine_if.sv | 18 +
 rtl/baud_decode.sv | 25 ++
 rtl/rx_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_rx_engine.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART engines on the TramelBlaze I/O bus:
//   - baud table (baud select -> baud rate) and a bit-time function that
//     derives clocks-per-bit from the system clock frequency
//   - processor port addresses of the receive engine
//   - receive FSM state encoding
//   - parity helper
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic [15:0] RX_DATA = 16'h0000;
  localparam logic [15:0] RX_STAT = 16'h0001;

  localparam int BIT_TIME_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_e;

  // Baud rate selected by a 4-bit code; codes above 4'hA all select 921600.
  function automatic int unsigned baud_rate(input logic [3:0] sel);
    int unsigned rate;
    case (sel)
      4'h0:    rate = 32'd300;
      4'h1:    rate = 32'd1200;
      4'h2:    rate = 32'd2400;
      4'h3:    rate = 32'd4800;
      4'h4:    rate = 32'd9600;
      4'h5:    rate = 32'd19200;
      4'h6:    rate = 32'd38400;
      4'h7:    rate = 32'd57600;
      4'h8:    rate = 32'd115200;
      4'h9:    rate = 32'd230400;
      4'hA:    rate = 32'd460800;
      default: rate = 32'd921600;
    endcase
    return rate;
  endfunction

  // Clocks per bit, rounded to nearest (e.g. 100 MHz / 921600 -> 109).
  // Only ever called with constant arguments, so it folds to a table.
  function automatic logic [BIT_TIME_W-1:0] baud_bit_time(input logic [3:0] sel,
                                                          input int unsigned clk_hz);
    int unsigned rate;
    int unsigned t;
    rate = baud_rate(sel);
    t    = (clk_hz + (rate >> 1)) / rate;
    return t[BIT_TIME_W-1:0];
  endfunction

  // 1 when the byte holds an odd number of ones.
  function automatic logic parity_of(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_engine_if.sv
// ---------------------------------------------------------------------------
// rx_engine_if
// Processor read path of the UART receive engine.
//   port_id     processor port address
//   read_strobe processor read qualifier
//   in_port     read data (16'h0000 when the engine is not addressed)
//   rx_rdy      level: an unread byte is held
// master = processor side, slave = receive engine.
// ---------------------------------------------------------------------------
interface rx_engine_if;
  logic [15:0] port_id;
  logic        read_strobe;
  logic [15:0] in_port;
  logic        rx_rdy;

  modport master (output port_id, output read_strobe, input in_port, input rx_rdy);
  modport slave  (input port_id, input read_strobe, output in_port, output rx_rdy);
endinterface

// File: rtl/baud_decode.sv
// ---------------------------------------------------------------------------
// baud_decode
// Maps the 4-bit baud select to a bit time in system clocks.
//   baud_in   in  4   baud select
//   bit_time  out 19  clocks per bit for that select
// Parameter CLK_HZ: system clock frequency the table is derived from.
// ---------------------------------------------------------------------------
module baud_decode
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic [3:0]            baud_in,
  output logic [BIT_TIME_W-1:0] bit_time
);

  logic [BIT_TIME_W-1:0] table_s [16];

  for (genvar g = 0; g < 16; g++) begin : g_tab
    assign table_s[g] = baud_bit_time(4'(g), CLK_HZ);
  end

  assign bit_time = table_s[baud_in];

endmodule

// File: rtl/rx_engine.sv
// ---------------------------------------------------------------------------
// rx_engine
// UART receive engine. Recovers 1-start / 7-or-8-data / optional parity /
// 1-stop frames from rx, sampling at mid-bit, and exposes data and status on
// the processor read path.
//   clk      in  1   system clock
//   reset    in  1   synchronous, active-high reset
//   rx       in  1   asynchronous serial input, idles high
//   baud_in  in  4   baud select
//   Eight    in  1   1 = 8 data bits, 0 = 7 data bits
//   Pen      in  1   parity enable
//   OHEL     in  1   parity sense: 1 = odd, 0 = even
//   bus      slave   port_id/read_strobe in, in_port/rx_rdy out
// Read map: RX_DATA -> {8'h00, data} and clears rx_rdy and the error flags;
//           RX_STAT -> {12'h000, ovf, ferr, perr, rx_rdy}, no side effects.
// ---------------------------------------------------------------------------
module rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [3:0]  baud_in,
  input  logic        Eight,
  input  logic        Pen,
  input  logic        OHEL,
  rx_engine_if.slave  bus
);

  rx_state_e             state_r, state_nx_s;
  logic                  rx_meta_r, rx_sync_r;
  logic [3:0]            baud_r;
  logic                  eight_r, pen_r, ohel_r;
  logic                  latch_s;
  logic [3:0]            baud_sel_s;
  logic [BIT_TIME_W-1:0] bit_time_s, half_time_s, full_time_s;
  logic [BIT_TIME_W-1:0] cnt_r, cnt_nx_s;
  logic                  expire_s;
  logic [3:0]            bits_r, bits_nx_s;
  logic [3:0]            nbits_s;
  logic [9:0]            shift_r, shift_nx_s;
  logic [9:0]            frame_s;
  logic [7:0]            data_nx_s;
  logic                  par_bit_s, stop_bit_s, perr_nx_s, ferr_nx_s;
  logic [7:0]            data_r;
  logic                  rdy_r, perr_r, ferr_r, ovf_r;
  logic                  rd_data_s, rd_stat_s;

  // Two-flop synchronizer; idles high so reset cannot fake a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // In IDLE the half-bit load must use the live select; afterwards the latched one
  always_comb begin
    baud_sel_s = baud_r;
    if (state_r == ST_IDLE) begin
      baud_sel_s = baud_in;
    end else begin
      baud_sel_s = baud_r;
    end
  end

  baud_decode #(.CLK_HZ(CLK_HZ)) u_baud_decode (
    .baud_in  (baud_sel_s),
    .bit_time (bit_time_s)
  );

  assign half_time_s = {1'b0, bit_time_s[BIT_TIME_W-1:1]} - 19'd1;
  assign full_time_s = bit_time_s - 19'd1;
  assign expire_s    = (cnt_r == 19'd0);
  // data bits + parity + stop
  assign nbits_s     = 4'd8 + {3'b000, eight_r} + {3'b000, pen_r};

  // Next-state, bit timer, bit counter and shift register
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    bits_nx_s  = bits_r;
    shift_nx_s = shift_r;
    latch_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          latch_s    = 1'b1;
          cnt_nx_s   = half_time_s;
          shift_nx_s = 10'd0;
          state_nx_s = ST_START;
        end else begin
          cnt_nx_s   = 19'd0;
        end
      end
      ST_START: begin
        if (expire_s) begin
          if (!rx_sync_r) begin
            cnt_nx_s   = full_time_s;
            bits_nx_s  = nbits_s;
            state_nx_s = ST_DATA;
          end else begin
            // line went high again before mid-start: glitch, not a frame
            state_nx_s = ST_IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r - 19'd1;
        end
      end
      ST_DATA: begin
        if (expire_s) begin
          shift_nx_s = {rx_sync_r, shift_r[9:1]};
          bits_nx_s  = bits_r - 4'd1;
          cnt_nx_s   = full_time_s;
          if (bits_r == 4'd1) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_DATA;
          end
        end else begin
          cnt_nx_s = cnt_r - 19'd1;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers and per-frame control latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 19'd0;
      bits_r  <= 4'd0;
      shift_r <= 10'd0;
      baud_r  <= 4'd0;
      eight_r <= 1'b0;
      pen_r   <= 1'b0;
      ohel_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      bits_r  <= bits_nx_s;
      shift_r <= shift_nx_s;
      if (latch_s) begin
        baud_r  <= baud_in;
        eight_r <= Eight;
        pen_r   <= Pen;
        ohel_r  <= OHEL;
      end
    end
  end

  // Right-justify the N received bits and decode data, parity and stop
  always_comb begin
    frame_s    = shift_r >> (4'd10 - nbits_s);
    data_nx_s  = 8'h00;
    par_bit_s  = 1'b0;
    if (eight_r) begin
      data_nx_s = frame_s[7:0];
      par_bit_s = frame_s[8];
    end else begin
      data_nx_s = {1'b0, frame_s[6:0]};
      par_bit_s = frame_s[7];
    end
    stop_bit_s = frame_s[nbits_s - 4'd1];
    perr_nx_s  = pen_r & (par_bit_s != (parity_of(data_nx_s) ^ ohel_r));
    ferr_nx_s  = ~stop_bit_s;
  end

  assign rd_data_s = bus.read_strobe && (bus.port_id == RX_DATA);
  assign rd_stat_s = bus.read_strobe && (bus.port_id == RX_STAT);

  // Data/status registers; a frame completing on a data-read edge wins
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= 8'h00;
      rdy_r  <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state_r == ST_DONE) begin
      data_r <= data_nx_s;
      perr_r <= perr_nx_s;
      ferr_r <= ferr_nx_s;
      ovf_r  <= rdy_r & ~rd_data_s;
      rdy_r  <= 1'b1;
    end else if (rd_data_s) begin
      rdy_r  <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      rdy_r  <= rdy_r;
    end
  end

  // Read mux; zero when not addressed so ports can be OR-combined
  always_comb begin
    bus.in_port = 16'h0000;
    if (rd_data_s) begin
      bus.in_port = {8'h00, data_r};
    end else if (rd_stat_s) begin
      bus.in_port = {12'h000, ovf_r, ferr_r, perr_r, rdy_r};
    end else begin
      bus.in_port = 16'h0000;
    end
  end

  assign bus.rx_rdy = rdy_r;

endmodule

// File: tb/tb_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_rx_engine
// Drives serial frames at 109 clocks per bit, keeps a frame-level model of
// what the engine must report (data, flags, when rx_rdy rises, what each read
// returns) and compares the DUT against it on every cycle, plus literal
// expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_rx_engine;

  localparam int BT = 109;
  // Latency from the edge that first sees rx low to the edge raising rx_rdy:
  // 2 synchronizer clocks + 1 detect + half bit + N full bits + 1 for DONE.
  localparam int LAT0 = 2 + 1 + (BT / 2) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] baud_in;
  logic       Eight, Pen, OHEL;

  rx_engine_if bus();

  rx_engine #(.CLK_HZ(100_000_000)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .baud_in (baud_in),
    .Eight   (Eight),
    .Pen     (Pen),
    .OHEL    (OHEL),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic rst_at_edge;

  // model state
  logic [7:0] m_data = 8'h00;
  bit         m_rdy, m_perr, m_ferr, m_ovf;
  bit         m_pend = 1'b0;
  int         m_due  = 0;
  logic [7:0] p_data;
  bit         p_perr, p_ferr;
  bit         prev_read = 1'b0;
  bit         chk_en = 1'b0;
  bit         frame_busy;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  // Advance the model to the register state after the latest edge, then compare
  always @(negedge clk) begin
    logic [15:0] exp_in;
    if (chk_en) begin
      if (rst_at_edge) begin
        m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        m_pend = 1'b0;
        prev_read = 1'b0;
      end else if (m_pend && cyc == m_due) begin
        m_ovf  = m_rdy && !prev_read;
        m_rdy  = 1'b1;
        m_data = p_data;
        m_perr = p_perr;
        m_ferr = p_ferr;
        m_pend = 1'b0;
      end else if (prev_read) begin
        m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      end
      exp_in = 16'h0000;
      if (bus.read_strobe && bus.port_id == 16'h0000) exp_in = {8'h00, m_data};
      else if (bus.read_strobe && bus.port_id == 16'h0001)
        exp_in = {12'h000, m_ovf, m_ferr, m_perr, m_rdy};
      chk("model_rx_rdy", {15'd0, bus.rx_rdy}, {15'd0, m_rdy});
      chk("model_in_port", bus.in_port, exp_in);
      prev_read = bus.read_strobe && bus.port_id == 16'h0000;
    end
  end

  // Send one frame bit by bit and tell the model what it must produce
  task automatic send_frame(input logic [7:0] d, input logic eight, input logic pen,
                            input logic ohel, input logic par_bit, input logic stop_bit,
                            input logic scramble);
    logic [9:0] bits;
    logic [7:0] dm;
    int         n;
    int         ones;
    dm   = eight ? d : {1'b0, d[6:0]};
    bits = 10'd0;
    n    = 0;
    for (int i = 0; i < (eight ? 8 : 7); i++) begin
      bits[n] = d[i];
      n++;
    end
    if (pen) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    ones = $countones(dm);
    baud_in = 4'hB; Eight = eight; Pen = pen; OHEL = ohel;
    @(posedge clk); #1;
    p_data = dm;
    p_perr = pen && (par_bit != ((ones % 2 == 1) ^ ohel));
    p_ferr = !stop_bit;
    m_due  = cyc + LAT0 + BT * n;
    m_pend = 1'b1;
    rx = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (BT) @(posedge clk);
      #1;
      rx = bits[i];
      if (scramble && i == 0) begin
        baud_in = 4'($urandom);
        Eight   = 1'($urandom);
        Pen     = 1'($urandom);
        OHEL    = 1'($urandom);
      end
    end
    repeat (BT) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (stop_bit ? 2 : BT) @(posedge clk);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
    @(posedge clk); #1;
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    @(negedge clk);
    chk(name, bus.in_port, exp);
    @(posedge clk); #1;
    bus.read_strobe = 1'b0;
    bus.port_id     = 16'h0000;
  endtask

  task automatic chk_rdy(input logic exp, input string name);
    @(negedge clk);
    chk(name, {15'd0, bus.rx_rdy}, {15'd0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx = 1'b1; baud_in = 4'hB; Eight = 1'b1; Pen = 1'b0; OHEL = 1'b0;
    bus.port_id = 16'h0000; bus.read_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1; chk_en = 1'b1;
    @(posedge clk); #1; reset = 1'b0;

    // reset state
    chk_rdy(1'b0, "reset_rx_rdy");
    chk("reset_in_port_idle", bus.in_port, 16'h0000);
    rd(16'h0001, 16'h0000, "reset_status");
    rd(16'h0000, 16'h0000, "reset_data");

    // 8N1 0x55
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rdy(1'b1, "8n1_rx_rdy");
    rd(16'h0000, 16'h0055, "8n1_data");
    chk_rdy(1'b0, "8n1_rdy_cleared");

    // 8-bit even parity 0xA5: parity bit 1 is wrong, 0 is right
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(16'h0001, 16'h0003, "even_bad_status");
    rd(16'h0000, 16'h00A5, "even_bad_data");
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(16'h0001, 16'h0001, "even_ok_status");
    rd(16'h0000, 16'h00A5, "even_ok_data");

    // 7-bit odd parity 0x7F, then with a bad stop bit
    send_frame(8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rd(16'h0001, 16'h0001, "odd7_status");
    rd(16'h0000, 16'h007F, "odd7_data");
    send_frame(8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(16'h0001, 16'h0005, "odd7_ferr_status");
    rd(16'h0000, 16'h007F, "odd7_ferr_data");

    // overrun: two frames, no read between
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(16'h0001, 16'h0009, "ovf_status");
    rd(16'h0000, 16'h0034, "ovf_data");
    rd(16'h0001, 16'h0000, "ovf_cleared");

    // 30-clock glitch is rejected, then a real frame
    @(posedge clk); #1; rx = 1'b0;
    repeat (30) @(posedge clk);
    #1; rx = 1'b1;
    repeat (300) @(posedge clk);
    chk_rdy(1'b0, "glitch_rx_rdy");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(16'h0000, 16'h00C3, "after_glitch_data");

    // data read on the same edge a new frame completes: new frame wins
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        @(posedge clk);
        repeat (LAT0 - 1 + BT * 9) @(posedge clk);
        #1; bus.port_id = 16'h0000; bus.read_strobe = 1'b1;
        @(negedge clk);
        chk("collide_read", bus.in_port, 16'h0011);
        @(posedge clk); #1; bus.read_strobe = 1'b0;
      end
    join
    rd(16'h0001, 16'h0005, "collide_status");
    rd(16'h0000, 16'h0022, "collide_data");

    // reset during the 4th data bit discards the partial frame and the held byte
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    baud_in = 4'hB; Eight = 1'b1; Pen = 1'b0;
    @(posedge clk); #1; rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (BT) @(posedge clk);
      #1; rx = i[0];
    end
    repeat (BT / 2) @(posedge clk);
    #1; reset = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    chk_rdy(1'b0, "midreset_rx_rdy");
    rd(16'h0001, 16'h0000, "midreset_status");
    repeat (2 * BT) @(posedge clk);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(16'h0000, 16'h0081, "after_reset_data");

    // random frames, random format, controls scrambled mid-frame, random reads
    for (int f = 0; f < 16; f++) begin
      frame_busy = 1'b1;
      fork
        begin
          send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), ($urandom_range(0, 5) != 0), 1'b1);
          frame_busy = 1'b0;
        end
        begin
          while (frame_busy) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 39) == 0) begin
              bus.read_strobe = 1'b1;
              case ($urandom_range(0, 3))
                0:       bus.port_id = 16'h0000;
                1:       bus.port_id = 16'h0001;
                2:       bus.port_id = 16'h0002;
                default: bus.port_id = 16'h8000;
              endcase
            end else begin
              bus.read_strobe = 1'b0;
              bus.port_id     = 16'($urandom);
            end
          end
          bus.read_strobe = 1'b0;
          bus.port_id     = 16'h0000;
        end
      join
      if ($urandom_range(0, 1) == 1) begin
        rd(16'h0000, {8'h00, m_data}, "rand_data");
      end
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
